// File: rtl/arm_pkg.sv
// Shared definitions for the SRAM controller.
//   state_t          : access sequencer states
//   *_DEF            : default values for the controller parameters
//   CNT_W            : wait-counter width (covers WAIT_CYCLES up to 15)
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned WAIT_CYCLES_DEF = 5;
  localparam int unsigned ADDR_BASE_DEF   = 1024;
  localparam int unsigned SRAM_AW_DEF     = 18;
  localparam int          CNT_W           = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with zero flag; times each halfword phase.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (saturates at zero)
//   zero       : count == 0
module sram_wait_counter
  import arm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage responder: one 32-bit load/store per request, carried out as two
// 16-bit SRAM accesses (low halfword, then high halfword).
// Optional feature: define SRAM_CTRL_READ_BYPASS_EN for a one-entry last-read
// buffer that completes repeat loads in IDLE without touching the SRAM.
//
// State table:
//   IDLE | waiting for rd_en/wr_en
//   LO   | low halfword on the SRAM pins for WAIT_CYCLES cycles
//   HI   | high halfword on the SRAM pins for WAIT_CYCLES cycles
//   DONE | completion cycle, ready=1
//
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   rd_en, wr_en           : load / store request (both high = store)
//   address, write_data    : byte address, store data
//   read_data              : load data, valid when ready completes a load
//   ready                  : 0 = stall the pipeline
//   sram_addr              : halfword address
//   sram_dq_out/in/oe      : SRAM data bus out / in / output enable
//   sram_we_n              : active-low write strobe
module sram_controller
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  state_t             state, state_nxt;
  logic               req, hit, start;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word, word_q;
  logic               op_wr;
  logic [15:0]        wdata_hi_q, rd_lo_q;
  logic [31:0]        rd_q, hit_data;
  logic               unused_offset;

  assign req    = rd_en | wr_en;
  assign offset = address - 32'(ADDR_BASE);
  assign word   = offset[SRAM_AW:2];
  assign unused_offset = &{1'b0, offset[31:SRAM_AW+1], offset[1:0]};
  assign start  = (state == IDLE) && req && !hit;

`ifdef SRAM_CTRL_READ_BYPASS_EN
  logic               buf_valid;
  logic [SRAM_AW-2:0] buf_word;
  logic [31:0]        buf_data;

  assign hit      = (state == IDLE) && rd_en && !wr_en && buf_valid && (buf_word == word);
  assign hit_data = buf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else if (start && wr_en) begin
      buf_valid <= 1'b0;
    end else if ((state == HI) && cnt_zero && !op_wr) begin
      buf_valid <= 1'b1;
      buf_word  <= word_q;
      buf_data  <= {sram_dq_in, rd_lo_q};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  sram_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = LO;
        cnt_load  = 1'b1;
      end
      LO: if (cnt_zero) begin
        state_nxt = HI;
        cnt_load  = 1'b1;
      end else begin
        cnt_dec = 1'b1;
      end
      HI: if (cnt_zero) state_nxt = DONE;
          else          cnt_dec   = 1'b1;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_wr       <= 1'b0;
      word_q      <= '0;
      wdata_hi_q  <= '0;
      rd_lo_q     <= '0;
      rd_q        <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      state <= state_nxt;
      if (hit) rd_q <= hit_data;
      case (state)
        IDLE: if (start) begin
          op_wr      <= wr_en;
          word_q     <= word;
          wdata_hi_q <= write_data[31:16];
          sram_addr  <= {word, 1'b0};
          if (wr_en) sram_dq_out <= write_data[15:0];
        end
        LO: if (cnt_zero) begin
          sram_addr <= {word_q, 1'b1};
          if (op_wr) sram_dq_out <= wdata_hi_q;
          else       rd_lo_q     <= sram_dq_in;
        end
        // read_data changes only when the whole word is in, so it holds
        // the previous load's value for the full duration of a new load.
        HI: if (cnt_zero && !op_wr) rd_q <= {sram_dq_in, rd_lo_q};
        default: ;
      endcase
    end
  end

  // Strobe released on the last cycle of each phase to give data hold time.
  assign sram_dq_oe = op_wr && ((state == LO) || (state == HI));
  assign sram_we_n  = !(sram_dq_oe && !cnt_zero);
  assign ready      = hit || !(req && (state != DONE));
  assign read_data  = hit ? hit_data : rd_q;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  // SRAM model: a strobe cycle arms a write, committed on the hold cycle
  // (we_n back high with the bus still driven). An aborted strobe never commits.
  logic [15:0] mem [0:255] = '{default: 16'h0000};
  logic        pend = 1'b0;
  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (!sram_we_n) pend <= 1'b1;
    else begin
      if (pend && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
      pend <= 1'b0;
    end
  end

  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [16:0] exp_word,
                            output int lat, output logic [31:0] rdata,
                            output int we_lo, output int we_hi, output int oe_cnt,
                            output int bad);
    @(negedge clk);
    rd_en = r; wr_en = w; address = a; write_data = d;
    lat = 0; we_lo = 0; we_hi = 0; oe_cnt = 0; bad = 0;
    #1;
    while (!ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (sram_dq_oe) begin
        oe_cnt++;
        if (sram_addr[17:1] !== exp_word) bad++;
        if (sram_dq_out !== (sram_addr[0] ? d[31:16] : d[15:0])) bad++;
      end
      if (!sram_we_n) begin
        if (sram_addr[0]) we_hi++; else we_lo++;
      end
    end
    rdata = read_data;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (read_data !== 32'h0) $display("FAIL reset_read_data got %h want 0", read_data); else n_pass++;
    n_checks++; if (sram_addr !== 18'h0) $display("FAIL reset_sram_addr got %h want 0", sram_addr); else n_pass++;
    n_checks++; if (sram_dq_out !== 16'h0) $display("FAIL reset_dq_out got %h want 0", sram_dq_out); else n_pass++;
    n_checks++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_dq_oe got %b want 0", sram_dq_oe); else n_pass++;
    n_checks++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n got %b want 1", sram_we_n); else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store;
    int lat, lo, hi, oe, bad; logic [31:0] rd;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'd0, lat, rd, lo, hi, oe, bad);
    n_checks++; if (lat !== 11) $display("FAIL store_latency got %0d want 11", lat); else n_pass++;
    n_checks++; if (lo !== 4) $display("FAIL store_we_lo got %0d want 4", lo); else n_pass++;
    n_checks++; if (hi !== 4) $display("FAIL store_we_hi got %0d want 4", hi); else n_pass++;
    n_checks++; if (oe !== 10) $display("FAIL store_oe_cycles got %0d want 10", oe); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL store_pins got %0d bad want 0", bad); else n_pass++;
    n_checks++; if (mem[0] !== 16'hBEEF) $display("FAIL store_mem_lo got %h want beef", mem[0]); else n_pass++;
    n_checks++; if (mem[1] !== 16'hDEAD) $display("FAIL store_mem_hi got %h want dead", mem[1]); else n_pass++;
  endtask

  task automatic test_load;
    int lat, lo, hi, oe, bad; logic [31:0] rd;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0, lat, rd, lo, hi, oe, bad);
    n_checks++; if (lat !== 11) $display("FAIL load_latency got %0d want 11", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL load_data got %h want deadbeef", rd); else n_pass++;
    n_checks++; if ((oe + lo + hi) !== 0) $display("FAIL load_bus_driven got %0d want 0", oe + lo + hi); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, lo, hi, oe, bad; logic [31:0] rd;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1028; write_data = 32'h12345678;
    lat = 0; #1;
    while (!ready && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 11) $display("FAIL b2b_store_latency got %0d want 11", lat); else n_pass++;
    @(negedge clk);  // still in DONE: present the load now
    wr_en = 1'b0; rd_en = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b0) $display("FAIL b2b_load_started got ready=%b want 0", ready); else n_pass++;
    lat = 0;
    while (!ready && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 11) $display("FAIL b2b_load_latency got %0d want 11", lat); else n_pass++;
    n_checks++; if (read_data !== 32'h12345678) $display("FAIL b2b_load_data got %h want 12345678", read_data); else n_pass++;
    @(negedge clk); rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    int guard;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFEF00D;
    guard = 0;
    do begin @(posedge clk); #1; guard++; end
    while (!(sram_addr == 18'd7 && !sram_we_n) && guard < 100);
    n_checks++; if (guard >= 100) $display("FAIL abort_reach_hi got timeout want hi phase"); else n_pass++;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (sram_we_n !== 1'b1) $display("FAIL abort_we_n got %b want 1", sram_we_n); else n_pass++;
    n_checks++; if (sram_dq_oe !== 1'b0) $display("FAIL abort_dq_oe got %b want 0", sram_dq_oe); else n_pass++;
    wr_en = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (read_data !== 32'h0) $display("FAIL abort_read_data got %h want 0", read_data); else n_pass++;
    n_checks++; if (mem[6] !== 16'hF00D) $display("FAIL abort_mem_lo got %h want f00d", mem[6]); else n_pass++;
    n_checks++; if (mem[7] !== 16'h0000) $display("FAIL abort_mem_hi got %h want 0000", mem[7]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rd_wr_both;
    int lat, lo, hi, oe, bad; logic [31:0] rd;
    run_access(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 17'd2, lat, rd, lo, hi, oe, bad);
    n_checks++; if (oe !== 10) $display("FAIL both_is_write got oe=%0d want 10", oe); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL both_pins got %0d bad want 0", bad); else n_pass++;
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 17'd2, lat, rd, lo, hi, oe, bad);
    n_checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL both_readback got %h want a5a5a5a5", rd); else n_pass++;
  endtask

`ifdef SRAM_CTRL_READ_BYPASS_EN
  task automatic test_bypass;
    int lat, lo, hi, oe, bad; logic [31:0] rd; logic [17:0] a0;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0, lat, rd, lo, hi, oe, bad);
    n_checks++; if (lat !== 11) $display("FAIL bypass_fill_latency got %0d want 11", lat); else n_pass++;
    a0 = sram_addr;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0, lat, rd, lo, hi, oe, bad);
    n_checks++; if (lat !== 0) $display("FAIL bypass_hit_latency got %0d want 0", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL bypass_hit_data got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (sram_addr !== a0) $display("FAIL bypass_pins got %h want %h", sram_addr, a0); else n_pass++;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'd0, lat, rd, lo, hi, oe, bad);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0, lat, rd, lo, hi, oe, bad);
    n_checks++; if (lat !== 11) $display("FAIL bypass_invalidate got %0d want 11", lat); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_store;
    test_load;
    test_back_to_back;
    test_reset_mid_access;
    test_rd_wr_both;
`ifdef SRAM_CTRL_READ_BYPASS_EN
    test_bypass;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
